// File: rtl/axi_lite_mem_arbiter_if.sv
// axi_lite_mem_arbiter_if: AXI4-Lite bus bundle with master and slave views
interface axi_lite_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_mem_arbiter.sv
// axi_lite_mem_arbiter: 2:1 AXI4-Lite arbiter (IFU read-only, LSU read/write) in front of one SRAM slave
module axi_lite_mem_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_lite_mem_arbiter_if.slave  m0,
  axi_lite_mem_arbiter_if.slave  m1,
  axi_lite_mem_arbiter_if.master s,
  output logic [1:0]            grant
);
  typedef enum logic [1:0] {IDLE = 2'b00, G0_RD = 2'b01, G1_RD = 2'b10, G1_WR = 2'b11} state_t;
  state_t state_q, state_d;
  logic last_rd_q, last_rd_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic rd0, rd1, wr, r_fire, b_fire;
  assign rd0    = state_q == G0_RD;
  assign rd1    = state_q == G1_RD;
  assign wr     = state_q == G1_WR;
  assign r_fire = s.rvalid & s.rready;
  assign b_fire = s.bvalid & s.bready;
  // State register plus last read winner and write-channel completion flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_rd_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
  // Arbitrate in IDLE (write first, then round-robin or LSU-priority reads); leave a grant on R/B fire
  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE:  state_d = m1.awvalid ? G1_WR
                     : m1.arvalid ? ((m0.arvalid && RR_EN && last_rd_q) ? G0_RD : G1_RD)
                     : m0.arvalid ? G0_RD : IDLE;
      G0_RD: begin
        state_d   = r_fire ? IDLE : G0_RD;
        last_rd_d = r_fire ? 1'b0 : last_rd_q;
      end
      G1_RD: begin
        state_d   = r_fire ? IDLE : G1_RD;
        last_rd_d = r_fire ? 1'b1 : last_rd_q;
      end
      default: begin
        state_d   = b_fire ? IDLE : G1_WR;
        aw_done_d = ~b_fire & (aw_done_q | (s.awvalid & s.awready));
        w_done_d  = ~b_fire & (w_done_q | (s.wvalid & s.wready));
      end
    endcase
  end
  // Route the granted master to the slave; everything ungranted sees zero valids/readys
  always_comb begin
    grant      = state_q;
    s.araddr   = rd1 ? m1.araddr : m0.araddr;
    s.arvalid  = (rd0 & m0.arvalid) | (rd1 & m1.arvalid);
    s.rready   = (rd0 & m0.rready) | (rd1 & m1.rready);
    s.awaddr   = m1.awaddr;
    s.awvalid  = wr & ~aw_done_q & m1.awvalid;
    s.wdata    = m1.wdata;
    s.wstrb    = m1.wstrb;
    s.wvalid   = wr & ~w_done_q & m1.wvalid;
    s.bready   = wr & m1.bready;
    m0.arready = rd0 & s.arready;
    m0.rvalid  = rd0 & s.rvalid;
    m0.rdata   = s.rdata;
    m0.rresp   = s.rresp;
    m0.awready = 1'b0;
    m0.wready  = 1'b0;
    m0.bvalid  = 1'b0;
    m0.bresp   = s.bresp;
    m1.arready = rd1 & s.arready;
    m1.rvalid  = rd1 & s.rvalid;
    m1.rdata   = s.rdata;
    m1.rresp   = s.rresp;
    m1.awready = wr & ~aw_done_q & s.awready;
    m1.wready  = wr & ~w_done_q & s.wready;
    m1.bvalid  = wr & s.bvalid;
    m1.bresp   = s.bresp;
  end
endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// tb_axi_lite_mem_arbiter: scoreboard bench with a behavioural SRAM slave and random master traffic
module tb_axi_lite_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] grant;
  int total = 0;
  int bad = 0;
  logic [33:0] exp_r0[$];
  logic [33:0] exp_r1[$];
  logic [1:0]  exp_b[$];
  logic [1:0]  glog[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] smem[logic [31:0]];

  axi_lite_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0 ();
  axi_lite_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1 ();
  axi_lite_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s ();

  axi_lite_mem_arbiter #(.RR_EN(1'b1)) dut (.clk(clk), .rst(rst), .m0(m0), .m1(m1), .s(s), .grant(grant));

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [11:0] io_vec();
    return {s.arvalid, s.rready, s.awvalid, s.wvalid, s.bready, m0.arready, m0.rvalid,
            m1.arready, m1.rvalid, m1.awready, m1.wready, m1.bvalid};
  endfunction

  function automatic bit hs(input int c);
    case (c)
      0: return m0.arvalid && m0.arready;
      1: return m0.rvalid && m0.rready;
      2: return m1.arvalid && m1.arready;
      3: return m1.rvalid && m1.rready;
      4: return m1.awvalid && m1.awready;
      5: return m1.wvalid && m1.wready;
      6: return m1.bvalid && m1.bready;
      7: return m0.rvalid;
      8: return m1.rvalid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm, input string why);
    total++;
    bad++;
    $display("FAIL %s: %s", nm, why);
  endtask

  task automatic wait_ev(input int c, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!hs(c) && n < 300);
    if (!hs(c)) flag(nm, "got no handshake want one within 300 cycles");
    @(posedge clk);
    #1;
  endtask

  task automatic m0_read(input logic [31:0] a, input int rdly, input bit hold_chk);
    @(posedge clk);
    #1;
    exp_r0.push_back({rd_ref(a), a[5:4]});
    m0.araddr = a;
    m0.arvalid = 1'b1;
    wait_ev(0, "m0_ar");
    m0.arvalid = 1'b0;
    if (rdly > 0) begin
      wait_ev(7, "m0_rvalid");
      repeat (rdly) begin
        @(negedge clk);
        if (hold_chk) chk("hold_grant", grant, 2'b01);
      end
      @(posedge clk);
      #1;
    end
    m0.rready = 1'b1;
    wait_ev(1, "m0_r");
    m0.rready = 1'b0;
  endtask

  task automatic m1_read(input logic [31:0] a, input int rdly);
    @(posedge clk);
    #1;
    exp_r1.push_back({rd_ref(a), a[5:4]});
    m1.araddr = a;
    m1.arvalid = 1'b1;
    wait_ev(2, "m1_ar");
    m1.arvalid = 1'b0;
    if (rdly > 0) begin
      wait_ev(8, "m1_rvalid");
      repeat (rdly) @(posedge clk);
      #1;
    end
    m1.rready = 1'b1;
    wait_ev(3, "m1_r");
    m1.rready = 1'b0;
  endtask

  task automatic m1_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                          input int aw_dly, input int w_dly);
    exp_b.push_back(a[5:4]);
    ref_mem[a] = merge(rd_ref(a), d, st);
    @(posedge clk);
    #1;
    fork
      begin
        repeat (aw_dly) begin
          @(posedge clk);
          #1;
        end
        m1.awaddr = a;
        m1.awvalid = 1'b1;
        wait_ev(4, "m1_aw");
        m1.awvalid = 1'b0;
      end
      begin
        repeat (w_dly) begin
          @(posedge clk);
          #1;
        end
        m1.wdata = d;
        m1.wstrb = st;
        m1.wvalid = 1'b1;
        wait_ev(5, "m1_w");
        m1.wvalid = 1'b0;
      end
    join
    m1.bready = 1'b1;
    wait_ev(6, "m1_b");
    m1.bready = 1'b0;
  endtask

  // SRAM slave: random readys, one-or-more cycle response latency, responses held until accepted
  initial begin
    bit ar_f, r_f, aw_f, w_f, b_f, rs, rd_pend, aw_got, w_got;
    logic [31:0] ara, awa, wd, rd_a, wr_a, wr_d;
    logic [3:0] ws, wr_s;
    {s.arready, s.rvalid, s.awready, s.wready, s.bvalid} = '0;
    s.rdata = '0;
    s.rresp = '0;
    s.bresp = '0;
    {rd_pend, aw_got, w_got} = '0;
    {rd_a, wr_a, wr_d, wr_s} = '0;
    forever begin
      @(negedge clk);
      rs = rst;
      ar_f = s.arvalid && s.arready;
      r_f = s.rvalid && s.rready;
      aw_f = s.awvalid && s.awready;
      w_f = s.wvalid && s.wready;
      b_f = s.bvalid && s.bready;
      ara = s.araddr;
      awa = s.awaddr;
      wd = s.wdata;
      ws = s.wstrb;
      @(posedge clk);
      #1;
      if (rs) begin
        {s.arready, s.rvalid, s.awready, s.wready, s.bvalid} = '0;
        {rd_pend, aw_got, w_got} = '0;
      end else begin
        if (r_f) s.rvalid = 1'b0;
        if (b_f) s.bvalid = 1'b0;
        if (ar_f) begin
          rd_pend = 1'b1;
          rd_a = ara;
        end
        if (aw_f) begin
          aw_got = 1'b1;
          wr_a = awa;
        end
        if (w_f) begin
          w_got = 1'b1;
          wr_d = wd;
          wr_s = ws;
        end
        if (rd_pend && !s.rvalid && $urandom_range(0, 1) == 1) begin
          s.rvalid = 1'b1;
          s.rdata = smem.exists(rd_a) ? smem[rd_a] : init_val(rd_a);
          s.rresp = rd_a[5:4];
          rd_pend = 1'b0;
        end
        if (aw_got && w_got && !s.bvalid) begin
          smem[wr_a] = merge(smem.exists(wr_a) ? smem[wr_a] : init_val(wr_a), wr_d, wr_s);
          s.bvalid = 1'b1;
          s.bresp = wr_a[5:4];
          aw_got = 1'b0;
          w_got = 1'b0;
        end
        s.arready = !rd_pend && !s.rvalid && $urandom_range(0, 3) != 0;
        s.awready = !aw_got && !s.bvalid && $urandom_range(0, 3) != 0;
        s.wready = !w_got && !s.bvalid && $urandom_range(0, 3) != 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every response handshake and checks grant isolation each cycle
  initial begin
    logic [1:0] g, pg;
    int awc, wc;
    pg = 2'b00;
    awc = 0;
    wc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pg = 2'b00;
        awc = 0;
        wc = 0;
      end else begin
        g = grant;
        chk("quiet", {g != 2'b01 && (m0.arready || m0.rvalid),
                      g != 2'b10 && (m1.arready || m1.rvalid),
                      g != 2'b11 && (m1.awready || m1.wready || m1.bvalid || s.awvalid || s.wvalid || s.bready),
                      g[0] == g[1] && (s.arvalid || s.rready),
                      awc != 0 && s.awvalid,
                      wc != 0 && s.wvalid}, 6'b0);
        if (hs(1)) begin
          if (exp_r0.size() == 0) flag("m0_r", "got response want none");
          else chk("m0_r", {m0.rdata, m0.rresp}, exp_r0.pop_front());
        end
        if (hs(3)) begin
          if (exp_r1.size() == 0) flag("m1_r", "got response want none");
          else chk("m1_r", {m1.rdata, m1.rresp}, exp_r1.pop_front());
        end
        if (hs(6)) begin
          if (exp_b.size() == 0) flag("m1_b", "got response want none");
          else chk("m1_b", m1.bresp, exp_b.pop_front());
          chk("aw_w_once", {8'(awc), 8'(wc)}, 16'h0101);
          awc = 0;
          wc = 0;
        end
        if (s.awvalid && s.awready) awc++;
        if (s.wvalid && s.wready) wc++;
        if (pg == 2'b00 && g != 2'b00) glog.push_back(g);
        pg = g;
      end
    end
  end

  initial begin
    int n;
    logic [31:0] a;
    {m0.araddr, m0.awaddr, m0.wdata, m1.araddr, m1.awaddr, m1.wdata} = '0;
    {m0.wstrb, m1.wstrb} = '0;
    {m0.arvalid, m0.rready, m0.awvalid, m0.wvalid, m0.bready} = '0;
    {m1.arvalid, m1.rready, m1.awvalid, m1.wvalid, m1.bready} = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_io", io_vec(), 12'h0);

    @(posedge clk);
    #1;
    exp_r0.push_back({rd_ref(32'h8000_0000), 2'b00});
    m0.araddr = 32'h8000_0000;
    m0.arvalid = 1'b1;
    @(negedge clk);
    chk("t1_idle", grant, 2'b00);
    @(negedge clk);
    chk("t1_grant", grant, 2'b01);
    chk("t1_saddr", s.araddr, 32'h8000_0000);
    chk("t1_sarvalid", s.arvalid, 1'b1);
    if (hs(0)) begin
      @(posedge clk);
      #1;
    end else wait_ev(0, "t1_ar");
    m0.arvalid = 1'b0;
    m0.rready = 1'b1;
    wait_ev(1, "t1_r");
    m0.rready = 1'b0;
    @(negedge clk);
    chk("t1_done", grant, 2'b00);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    glog.delete();
    repeat (2) fork
      m0_read(32'h8000_0004, 0, 1'b0);
      m1_read(32'h1000_0000, 0);
    join
    chk("t2_order", {glog.size() == 4, glog[0], glog[1], glog[2], glog[3]}, 9'b1_10_01_10_01);

    fork
      m1_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0);
      begin
        @(posedge clk);
        m0_read(32'h8000_0010, 0, 1'b0);
      end
    join
    chk("t3_order", {glog[glog.size()-2], glog[glog.size()-1]}, 4'b11_01);

    m1_write(32'h1000_0004, 32'h1234_5678, 4'b0101, 0, 3);
    m1_read(32'h1000_0004, 0);

    fork
      m0_read(32'h8000_0020, 5, 1'b1);
      begin
        n = 0;
        while (grant != 2'b01 && n < 50) begin
          @(negedge clk);
          n++;
        end
        m1_read(32'h1000_0004, 0);
      end
    join
    chk("t5_order", {glog[glog.size()-2], glog[glog.size()-1]}, 4'b01_10);

    @(posedge clk);
    #1;
    m1.awaddr = 32'h1000_0008;
    m1.awvalid = 1'b1;
    wait_ev(4, "t6_aw");
    m1.awvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_grant", grant, 2'b00);
    chk("t6_io", io_vec(), 12'h0);
    m1_read(32'h1000_0008, 0);

    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        m0_read(32'h8000_0000 + 4 * $urandom_range(0, 15), $urandom_range(0, 2), 1'b0);
      end
      for (int j = 0; j < 40; j++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        a = 32'h1000_0000 + 4 * $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1)
          m1_write(a, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
        else
          m1_read(a, $urandom_range(0, 2));
      end
    join
    repeat (5) @(posedge clk);
    chk("sb_drained", exp_r0.size() + exp_r1.size() + exp_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
